// File: rtl/telem_pkg.sv
// Shared definitions for the telemetry link: delimiters, parser states
// and the default bit-period divisor used by both transmitter and receiver.
package telem_pkg;

  localparam logic [7:0] DELIM1 = 8'hAA;
  localparam logic [7:0] DELIM2 = 8'h55;

  // 50 MHz system clock / 19200 baud
  localparam int unsigned TELEM_BAUD_DIV = 2604;

  typedef enum logic [2:0] {
    SYNC1 = 3'd0,
    SYNC2 = 3'd1,
    P1    = 3'd2,
    P2    = 3'd3,
    P3    = 3'd4,
    P4    = 3'd5,
    P5    = 3'd6,
    P6    = 3'd7
  } telem_rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: two-flop synchroniser on the line, mid-bit sampling
// driven by a bit-period counter, LSB-first shift register. Emits a
// one-cycle rdy with the byte on a good stop bit, or ferr on a bad one.
module uart_rx
  import telem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = TELEM_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       ferr
);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);

  logic        s1_q, s2_q, prev_q;
  logic [2:0]  st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;

  // Synchronise the asynchronous line; preset high so reset looks like idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Bit-timing state machine: start-bit qualification, data shift, stop check.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    data_d = data_q;
    rdy_d  = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        if (prev_q && !s2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is high again at mid-bit was a glitch.
          st_d  = s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[7:1]};
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (s2_q) begin
            rdy_d  = 1'b1;
            data_d = sh_q;
          end else begin
            ferr_d = 1'b1;
          end
          st_d = RX_WAIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RX_WAIT: begin
        // A broken frame may leave the line low; re-arm only once it idles.
        if (s2_q) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= RX_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      data_q <= '0;
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      data_q <= data_d;
      rdy_q  <= rdy_d;
      ferr_q <= ferr_d;
    end
  end

  assign rx_data = data_q;
  assign rdy     = rdy_q;
  assign ferr    = ferr_q;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry frame receiver: AA 55 then six payload bytes carrying three
// 12-bit values. Re-syncs on the delimiter pair, aborts on bad high
// nibbles, framing errors or an over-long inter-byte gap, and updates all
// three outputs together with a one-cycle frm_vld.
// Optional build macro TELEM_RX_ERRCNT_EN enables the saturating err_cnt;
// without it err_cnt is tied to zero.
module telemetry_rx
  import telem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = TELEM_BAUD_DIV,
  parameter logic [19:0] GAP_TO   = 20'd104166
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        frm_vld,
  output logic        frm_err,
  output logic [7:0]  err_cnt
);

  logic [7:0] rx_data;
  logic       rdy;
  logic       ferr;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .rx_data (rx_data),
    .rdy     (rdy),
    .ferr    (ferr)
  );

  telem_rx_state_t state_q, state_d;
  logic [11:0] sh_batt_q, sh_batt_d;
  logic [11:0] sh_curr_q, sh_curr_d;
  logic [3:0]  sh_torq_hi_q, sh_torq_hi_d;
  logic [19:0] gap_q, gap_d;
  logic [11:0] batt_q, batt_d;
  logic [11:0] curr_q, curr_d;
  logic [11:0] torq_q, torq_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic        in_payload;

  assign in_payload = (state_q != SYNC1) && (state_q != SYNC2);

  // Frame parser: delimiter hunt, payload capture, abort paths, gap timeout.
  always_comb begin
    state_d      = state_q;
    sh_batt_d    = sh_batt_q;
    sh_curr_d    = sh_curr_q;
    sh_torq_hi_d = sh_torq_hi_q;
    gap_d        = gap_q;
    batt_d       = batt_q;
    curr_d       = curr_q;
    torq_d       = torq_q;
    vld_d        = 1'b0;
    err_d        = 1'b0;
    if (rdy) begin
      // A byte arriving on the timeout cycle still counts.
      gap_d = '0;
      case (state_q)
        SYNC1: if (rx_data == DELIM1) state_d = SYNC2;
        SYNC2: begin
          if (rx_data == DELIM2)      state_d = P1;
          else if (rx_data == DELIM1) state_d = SYNC2;
          else                        state_d = SYNC1;
        end
        P1, P3, P5: begin
          if (rx_data[7:4] != 4'h0) begin
            err_d   = 1'b1;
            state_d = SYNC1;
          end else begin
            case (state_q)
              P1:      sh_batt_d[11:8] = rx_data[3:0];
              P3:      sh_curr_d[11:8] = rx_data[3:0];
              default: sh_torq_hi_d    = rx_data[3:0];
            endcase
            state_d = telem_rx_state_t'(state_q + 3'd1);
          end
        end
        P2: begin
          sh_batt_d[7:0] = rx_data;
          state_d        = P3;
        end
        P4: begin
          sh_curr_d[7:0] = rx_data;
          state_d        = P5;
        end
        P6: begin
          // All three values commit in one edge, alongside frm_vld.
          batt_d  = sh_batt_q;
          curr_d  = sh_curr_q;
          torq_d  = {sh_torq_hi_q, rx_data};
          vld_d   = 1'b1;
          state_d = SYNC1;
        end
        default: state_d = SYNC1;
      endcase
    end else if (ferr) begin
      gap_d   = '0;
      err_d   = in_payload;
      state_d = SYNC1;
    end else if (in_payload) begin
      if (gap_q + 20'd1 == GAP_TO) begin
        err_d   = 1'b1;
        state_d = SYNC1;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + 20'd1;
      end
    end else begin
      gap_d = '0;
    end
  end

  // Parser, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC1;
      sh_batt_q    <= '0;
      sh_curr_q    <= '0;
      sh_torq_hi_q <= '0;
      gap_q        <= '0;
      batt_q       <= '0;
      curr_q       <= '0;
      torq_q       <= '0;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_batt_q    <= sh_batt_d;
      sh_curr_q    <= sh_curr_d;
      sh_torq_hi_q <= sh_torq_hi_d;
      gap_q        <= gap_d;
      batt_q       <= batt_d;
      curr_q       <= curr_d;
      torq_q       <= torq_d;
      vld_q        <= vld_d;
      err_q        <= err_d;
    end
  end

  assign batt_v     = batt_q;
  assign avg_curr   = curr_q;
  assign avg_torque = torq_q;
  assign frm_vld    = vld_q;
  assign frm_err    = err_q;

`ifdef TELEM_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Count discarded frames, holding at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_telemetry_rx.sv
// Scoreboard bench for telemetry_rx: directed frames push expected events,
// a negedge monitor pops and compares on every frm_vld / frm_err.
module tb_telemetry_rx;

  localparam int unsigned BD  = 16;
  localparam int unsigned GAP = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        frm_vld, frm_err;
  logic [7:0]  err_cnt;

  telemetry_rx #(.BAUD_DIV(BD), .GAP_TO(20'(GAP))) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .batt_v     (batt_v),
    .avg_curr   (avg_curr),
    .avg_torque (avg_torque),
    .frm_vld    (frm_vld),
    .frm_err    (frm_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [11:0] last_b = '0, last_c = '0, last_t = '0;
  int          err_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef TELEM_RX_ERRCNT_EN
    return 32'(err_exp);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0; tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i]; tick(BD);
    end
    RX = stop; tick(BD);
    RX = 1'b1; tick(BD);
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic expect_vld(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    q.push_back({1'b0, b, c, t});
    last_b = b; last_c = c; last_t = t;
  endtask

  task automatic expect_err();
    q.push_back({1'b1, last_b, last_c, last_t});
    if (err_exp < 255) err_exp++;
  endtask

  // Monitor: every output event must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (frm_vld || frm_err)) begin
      chk("vld_err_exclusive", {31'b0, frm_vld & frm_err}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_event", {30'b0, frm_vld, frm_err}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind_err", {31'b0, frm_err}, {31'b0, e.is_err});
        chk("batt_v", {20'b0, batt_v}, {20'b0, e.b});
        chk("avg_curr", {20'b0, avg_curr}, {20'b0, e.c});
        chk("avg_torque", {20'b0, avg_torque}, {20'b0, e.t});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RX = 1'b1;
    rst_n = 1'b0;
    tick(3);
    #1;
    chk("rst_batt", {20'b0, batt_v}, 32'd0);
    chk("rst_curr", {20'b0, avg_curr}, 32'd0);
    chk("rst_torq", {20'b0, avg_torque}, 32'd0);
    chk("rst_vld", {31'b0, frm_vld}, 32'd0);
    chk("rst_err", {31'b0, frm_err}, 32'd0);
    chk("rst_errcnt", {24'b0, err_cnt}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    tick(BD * 2);

    // Plain frame
    expect_vld(12'hA5C, 12'h321, 12'h7FF);
    send_frame(64'hAA550A5C032107FF);
    tick(4);

    // Leading junk and a repeated first delimiter
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    expect_vld(12'h102, 12'h304, 12'h506);
    send_frame(64'hAA55010203040506);
    tick(4);

    // Bad high nibble in P3
    expect_err();
    send_frame(64'hAA550A5C132107FF);
    tick(4);
    chk("errcnt_bad_nibble", {24'b0, err_cnt}, exp_cnt());
    chk("held_batt", {20'b0, batt_v}, 32'h102);

    // Frame stalls after P4 until the gap timeout
    expect_err();
    for (int i = 5; i >= 0; i--) send_byte(48'hAA5501020304 >> (i * 8), 1'b1);
    tick(GAP + 10);
    chk("errcnt_timeout", {24'b0, err_cnt}, exp_cnt());
    expect_vld(12'hFFF, 12'h000, 12'h800);
    send_frame(64'hAA550FFF00000800);
    tick(4);

    // Framing error on P2, then an idle glitch
    expect_err();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    tick(4);
    chk("errcnt_ferr", {24'b0, err_cnt}, exp_cnt());
    RX = 1'b0; tick(1); RX = 1'b1;
    tick(BD * 12);
    chk("errcnt_glitch", {24'b0, err_cnt}, exp_cnt());
    chk("glitch_torq_held", {20'b0, avg_torque}, 32'h800);
    expect_vld(12'h123, 12'h456, 12'h789);
    send_frame(64'hAA55012304560789);
    tick(4);

    // Reset in the middle of P5
    for (int i = 5; i >= 0; i--) send_byte(48'hAA5501020304 >> (i * 8), 1'b1);
    RX = 1'b0;
    tick(BD * 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_batt", {20'b0, batt_v}, 32'd0);
    chk("midrst_curr", {20'b0, avg_curr}, 32'd0);
    chk("midrst_torq", {20'b0, avg_torque}, 32'd0);
    chk("midrst_errcnt", {24'b0, err_cnt}, 32'd0);
    last_b = '0; last_c = '0; last_t = '0;
    err_exp = 0;
    RX = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(BD * 2);
    expect_vld(12'hABC, 12'hDEF, 12'h123);
    send_frame(64'hAA550ABC0DEF0123);

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 2000) begin
        tick(1);
        n++;
      end
    end
    tick(4);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_errcnt", {24'b0, err_cnt}, exp_cnt());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
